// File: rtl/sccb_master_write.sv
// ---------------------------------------------------------------------------
// sccb_master_write
//
// SCCB (I2C-like) three-phase write master for the OV7670 configuration path.
// Each accepted {sub_addr, data} pair is sent as one write frame on SIOC/SIOD:
// START, slave ID byte, register address byte, register data byte (each byte
// followed by one released don't-care slot), STOP, then a bus-free gap.
// The don't-care slot is never sampled, so this master is write-only and
// performs no acknowledge checking.
//
// Timing is built from quarter SIOC periods of Q = clk_freq/(4*sccb_freq)
// system clocks. A full frame is 118 quarters long:
//   START 2 | 27 bit slots x 4 | STOP 4 | GAP 4
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-low reset
//   sccb_start     in   write request, only looked at while sccb_ready=1
//   sccb_sub_addr  in   [7:0] OV7670 register address, latched on accept
//   sccb_data      in   [7:0] OV7670 register value, latched on accept
//   sccb_ready     out  1 = idle and able to accept a request
//   sioc           out  SCCB clock (registered)
//   siod           out  SCCB data value (registered)
//   siod_oe        out  1 = drive siod onto the pin, 0 = release it
// ---------------------------------------------------------------------------
module sccb_master_write #(
    parameter int         clk_freq  = 100000000,
    parameter int         sccb_freq = 100000,
    parameter logic [7:0] slave_id  = 8'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sccb_start,
    input  logic [7:0] sccb_sub_addr,
    input  logic [7:0] sccb_data,
    output logic       sccb_ready,
    output logic       sioc,
    output logic       siod,
    output logic       siod_oe
);

    // Clock cycles per quarter SIOC period and the width of its counter.
    localparam int            Q     = clk_freq / (4 * sccb_freq);
    localparam int            QW    = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [QW-1:0] QLAST = QW'(Q - 1);

    // Slot 26 is the final don't-care slot of the data byte.
    localparam logic [4:0] LAST_SLOT = 5'd26;

    // Reject parameter sets that cannot produce a legal waveform.
    generate
        if (Q < 2) begin : gen_bad_quarter
            $error("sccb_master_write: clk_freq/(4*sccb_freq) must be at least 2");
        end
        if (slave_id[0] != 1'b0) begin : gen_bad_slave_id
            $error("sccb_master_write: slave_id must be a write ID (bit 0 = 0)");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BITS,
        S_STOP,
        S_GAP
    } state_e;

    state_e        state_q,     state_d;
    logic [QW-1:0] qcnt_q,      qcnt_d;
    logic [1:0]    qidx_q,      qidx_d;
    logic [4:0]    bit_cnt_q,   bit_cnt_d;
    logic [7:0]    sub_addr_q,  sub_addr_d;
    logic [7:0]    data_q,      data_d;
    logic          ready_q,     ready_d;
    logic          sioc_q,      sioc_d;
    logic          siod_q,      siod_d;
    logic          oe_q,        oe_d;

    logic          tick;
    logic          accept;
    logic          dont_care;
    logic [26:0]   frame;

    // A quarter ends on the last count of the quarter counter.
    assign tick   = (qcnt_q == QLAST);

    // ready_q is only high in IDLE, so it doubles as the accept qualifier.
    assign accept = ready_q && sccb_start;

    // Whole frame as transmitted, slot 0 in the MSB. The don't-care slots
    // carry 1 so a released line also reads as 1.
    assign frame     = {slave_id, 1'b1, sub_addr_d, 1'b1, data_d, 1'b1};
    assign dont_care = (bit_cnt_d == 5'd8) || (bit_cnt_d == 5'd17) ||
                       (bit_cnt_d == LAST_SLOT);

    // State register, also holding the registered bus outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            qcnt_q     <= '0;
            qidx_q     <= '0;
            bit_cnt_q  <= '0;
            sub_addr_q <= '0;
            data_q     <= '0;
            ready_q    <= 1'b1;
            sioc_q     <= 1'b1;
            siod_q     <= 1'b1;
            oe_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            qidx_q     <= qidx_d;
            bit_cnt_q  <= bit_cnt_d;
            sub_addr_q <= sub_addr_d;
            data_q     <= data_d;
            ready_q    <= ready_d;
            sioc_q     <= sioc_d;
            siod_q     <= siod_d;
            oe_q       <= oe_d;
        end
    end

    // Next-state logic. The quarter counter free-runs whenever a frame is
    // active; qidx_q counts quarters within the current phase or bit slot.
    always_comb begin
        state_d    = state_q;
        qcnt_d     = qcnt_q;
        qidx_d     = qidx_q;
        bit_cnt_d  = bit_cnt_q;
        sub_addr_d = sub_addr_q;
        data_d     = data_q;

        if (state_q != S_IDLE) begin
            qcnt_d = tick ? '0 : qcnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d    = S_START;
                    qcnt_d     = '0;
                    qidx_d     = '0;
                    bit_cnt_d  = '0;
                    sub_addr_d = sccb_sub_addr;
                    data_d     = sccb_data;
                end
            end
            S_START: begin
                if (tick) begin
                    if (qidx_q == 2'd1) begin
                        state_d   = S_BITS;
                        qidx_d    = '0;
                        bit_cnt_d = '0;
                    end else begin
                        qidx_d = qidx_q + 2'd1;
                    end
                end
            end
            S_BITS: begin
                if (tick) begin
                    // qidx wraps 3 -> 0 at the end of every slot.
                    qidx_d = qidx_q + 2'd1;
                    if (qidx_q == 2'd3) begin
                        if (bit_cnt_q == LAST_SLOT) begin
                            state_d = S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    qidx_d = qidx_q + 2'd1;
                    if (qidx_q == 2'd3) begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    qidx_d = qidx_q + 2'd1;
                    if (qidx_q == 2'd3) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so that the registered outputs
    // change on exactly the edge that enters each quarter. SIOD only moves
    // at the start of a slot (q0, SIOC falling) except for the START and
    // STOP conditions, which move SIOD while SIOC is steadily high.
    always_comb begin
        ready_d = 1'b0;
        sioc_d  = 1'b1;
        siod_d  = 1'b1;
        oe_d    = 1'b1;

        case (state_d)
            S_IDLE: begin
                ready_d = 1'b1;
            end
            S_START: begin
                siod_d = 1'b0;
            end
            S_BITS: begin
                sioc_d = qidx_d[1];
                oe_d   = !dont_care;
                siod_d = dont_care ? 1'b1 : frame[LAST_SLOT - bit_cnt_d];
            end
            S_STOP: begin
                sioc_d = (qidx_d != 2'd0);
                siod_d = qidx_d[1];
            end
            S_GAP: begin
                sioc_d = 1'b1;
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

    assign sccb_ready = ready_q;
    assign sioc       = sioc_q;
    assign siod       = siod_q;
    assign siod_oe    = oe_q;

endmodule
